// File: rtl/layer_pkg.sv
// ---------------------------------------------------------------------------
// layer_pkg
// Shared types and constants for the layer output scheduler.
//   state_t        : scheduler FSM states
//   NUM_LAYERS_DEF : default number of output channels
//   BUSY_GUARD     : cycles after WAIT_BUSY entry during which busy is ignored
//   OVERRUN_W      : width of the saturating overrun counter
// ---------------------------------------------------------------------------
package layer_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        STAGGER   = 2'd1,
        WAIT_BUSY = 2'd2,
        HOLDOFF   = 2'd3
    } state_t;

    localparam int unsigned NUM_LAYERS_DEF = 8;
    localparam int unsigned BUSY_GUARD     = 2;
    localparam int unsigned OVERRUN_W      = 8;

endpackage

// File: rtl/layer_sched_if.sv
// ---------------------------------------------------------------------------
// layer_sched_if
// Handshake bundle between layer_ctl / layer_out channels and layer_sched.
//   frame_rdy_in    : one-cycle frame-complete pulse from layer_ctl
//   auto_en_in      : auto-refresh enable
//   layer_busy_in   : per-channel transmitting level
//   start_out       : one-cycle start pulse per channel
//   sched_busy_out  : scheduler not idle
//   auto_frame_out  : current frame was started by auto-refresh
//   timeout_out     : one-cycle busy-timeout pulse
//   overrun_cnt_out : saturating count of coalesced host frames
// Modports: slave = scheduler side, master = host/channel side.
// ---------------------------------------------------------------------------
interface layer_sched_if
    import layer_pkg::*;
#(
    parameter int unsigned NUM_LAYERS = NUM_LAYERS_DEF
);

    logic                  frame_rdy_in;
    logic                  auto_en_in;
    logic [NUM_LAYERS-1:0] layer_busy_in;
    logic [NUM_LAYERS-1:0] start_out;
    logic                  sched_busy_out;
    logic                  auto_frame_out;
    logic                  timeout_out;
    logic [OVERRUN_W-1:0]  overrun_cnt_out;

    modport slave (
        input  frame_rdy_in,
        input  auto_en_in,
        input  layer_busy_in,
        output start_out,
        output sched_busy_out,
        output auto_frame_out,
        output timeout_out,
        output overrun_cnt_out
    );

    modport master (
        output frame_rdy_in,
        output auto_en_in,
        output layer_busy_in,
        input  start_out,
        input  sched_busy_out,
        input  auto_frame_out,
        input  timeout_out,
        input  overrun_cnt_out
    );

endinterface

// File: rtl/sched_timer.sv
// ---------------------------------------------------------------------------
// sched_timer
// CNT_W-bit up-counter with synchronous clear, count enable and a terminal
// compare against TERM.
//   clk_in  : clock
//   rst_in  : asynchronous active-high reset (count -> 0)
//   clr_in  : synchronous clear, has priority over en_in
//   en_in   : count enable
//   hit_out : count == TERM
// ---------------------------------------------------------------------------
module sched_timer #(
    parameter int unsigned CNT_W = 24,
    parameter int unsigned TERM  = 0
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic clr_in,
    input  logic en_in,
    output logic hit_out
);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_in) begin
            cnt_d = '0;
        end else if (en_in) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_out = (cnt_q == CNT_W'(TERM));

endmodule

// File: rtl/layer_sched.sv
// ---------------------------------------------------------------------------
// layer_sched
// Frame output scheduler. Each host frame (or auto-refresh timeout) starts
// the channels one at a time, STAGGER_CYCLES apart, waits for all channels
// to go idle (bounded by BUSY_TIMEOUT) and enforces MIN_PERIOD between frame
// starts. Host frames arriving mid-frame coalesce into one pending request;
// further ones are counted as overruns.
//   clk_in : system clock
//   rst_in : asynchronous active-high reset
//   bus    : layer_sched_if.slave (frame_rdy/auto_en/layer_busy in;
//            start/sched_busy/auto_frame/timeout/overrun_cnt out)
// All outputs come from registers or registered state only.
// ---------------------------------------------------------------------------
module layer_sched
    import layer_pkg::*;
#(
    parameter int unsigned NUM_LAYERS     = NUM_LAYERS_DEF,
    parameter int unsigned STAGGER_CYCLES = 64,
    parameter int unsigned MIN_PERIOD     = 24000,
    parameter int unsigned REFRESH_PERIOD = 2400000,
    parameter int unsigned BUSY_TIMEOUT   = 1200000,
    parameter int unsigned CNT_W          = 24
) (
    input  logic           clk_in,
    input  logic           rst_in,
    layer_sched_if.slave   bus
);

    localparam int unsigned IDX_W       = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int unsigned GUARD_W     = $clog2(BUSY_GUARD + 1);
    localparam int unsigned STAG_TERM   = (STAGGER_CYCLES > 0) ? STAGGER_CYCLES - 1 : 0;
    localparam int unsigned PERIOD_TERM = (MIN_PERIOD > 0) ? MIN_PERIOD - 1 : 0;
    localparam int unsigned IDLE_TERM   = (REFRESH_PERIOD > 0) ? REFRESH_PERIOD - 1 : 0;
    localparam int unsigned BUSY_TERM   = (BUSY_TIMEOUT > 0) ? BUSY_TIMEOUT - 1 : 0;

    state_t               state_d, state_q;
    logic [IDX_W-1:0]     idx_d, idx_q;
    logic                 pending_d, pending_q;
    logic                 auto_d, auto_q;
    logic                 timeout_d, timeout_q;
    logic                 slot_first_d, slot_first_q;
    logic [OVERRUN_W-1:0] overrun_d, overrun_q;

    logic idle_hit;
    logic stag_hit;
    logic period_hit;
    logic busy_hit;
    logic guard_hit;
    logic [NUM_LAYERS-1:0] start;

    // ------------------------------------------------------------------
    // Timers
    // ------------------------------------------------------------------
    sched_timer #(.CNT_W(CNT_W), .TERM(IDLE_TERM)) u_idle_tmr (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .clr_in  ((state_q != IDLE) || !bus.auto_en_in),
        .en_in   (1'b1),
        .hit_out (idle_hit)
    );

    sched_timer #(.CNT_W(CNT_W), .TERM(STAG_TERM)) u_stag_tmr (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .clr_in  ((state_q != STAGGER) || stag_hit),
        .en_in   (state_q == STAGGER),
        .hit_out (stag_hit)
    );

    // Period timer parks on its terminal value, so hit_out reads as
    // "period >= MIN_PERIOD-1" for the rest of the frame.
    sched_timer #(.CNT_W(CNT_W), .TERM(PERIOD_TERM)) u_period_tmr (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .clr_in  (state_q == IDLE),
        .en_in   ((state_q != IDLE) && !period_hit),
        .hit_out (period_hit)
    );

    sched_timer #(.CNT_W(CNT_W), .TERM(BUSY_TERM)) u_busy_tmr (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .clr_in  (state_q != WAIT_BUSY),
        .en_in   (state_q == WAIT_BUSY),
        .hit_out (busy_hit)
    );

    // Start-to-busy latency guard: parks at BUSY_GUARD once reached.
    sched_timer #(.CNT_W(GUARD_W), .TERM(BUSY_GUARD)) u_guard_tmr (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .clr_in  (state_q != WAIT_BUSY),
        .en_in   ((state_q == WAIT_BUSY) && !guard_hit),
        .hit_out (guard_hit)
    );

    // ------------------------------------------------------------------
    // Next-state / datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        auto_d    = auto_q;
        overrun_d = overrun_q;
        timeout_d = 1'b0;

        // A pulse on the cycle returning to IDLE still counts as in-flight.
        if ((state_q != IDLE) && bus.frame_rdy_in) begin
            if (!pending_q) begin
                pending_d = 1'b1;
            end else if (overrun_q != '1) begin
                overrun_d = overrun_q + OVERRUN_W'(1);
            end
        end

        unique case (state_q)
            IDLE: begin
                auto_d = 1'b0;
                if (bus.frame_rdy_in || pending_q) begin
                    state_d   = STAGGER;
                    idx_d     = '0;
                    pending_d = 1'b0;
                end else if (bus.auto_en_in && idle_hit) begin
                    state_d = STAGGER;
                    idx_d   = '0;
                    auto_d  = 1'b1;
                end
            end
            STAGGER: begin
                if (stag_hit) begin
                    if (idx_q == IDX_W'(NUM_LAYERS - 1)) begin
                        state_d = WAIT_BUSY;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            WAIT_BUSY: begin
                if (guard_hit && (bus.layer_busy_in == '0)) begin
                    state_d = HOLDOFF;
                end else if (busy_hit) begin
                    state_d   = HOLDOFF;
                    timeout_d = 1'b1;
                end
            end
            HOLDOFF: begin
                if (period_hit) begin
                    state_d = IDLE;
                    auto_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Registered "stagger count is zero" flag: set on STAGGER entry and
        // on every slot wrap that stays in STAGGER.
        slot_first_d = (state_d == STAGGER) &&
                       ((state_q != STAGGER) || stag_hit);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            pending_q    <= 1'b0;
            auto_q       <= 1'b0;
            timeout_q    <= 1'b0;
            slot_first_q <= 1'b0;
            overrun_q    <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            auto_q       <= auto_d;
            timeout_q    <= timeout_d;
            slot_first_q <= slot_first_d;
            overrun_q    <= overrun_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (decoded from registered state only)
    // ------------------------------------------------------------------
    always_comb begin
        start = '0;
        if ((state_q == STAGGER) && slot_first_q) begin
            start[idx_q] = 1'b1;
        end
    end

    assign bus.start_out       = start;
    assign bus.sched_busy_out  = (state_q != IDLE);
    assign bus.auto_frame_out  = auto_q;
    assign bus.timeout_out     = timeout_q;
    assign bus.overrun_cnt_out = overrun_q;

endmodule

// File: tb/tb_layer_sched.sv
// ---------------------------------------------------------------------------
// tb_layer_sched
// Directed bench for layer_sched with NUM_LAYERS=8, STAGGER_CYCLES=4,
// MIN_PERIOD=100, REFRESH_PERIOD=500, BUSY_TIMEOUT=200. Cycle 0 is the first
// cycle after reset release; inputs change 1ns after a rising edge and
// outputs are read at the same point.
// ---------------------------------------------------------------------------
module tb_layer_sched;

    logic clk_in;
    logic rst_in;

    layer_sched_if #(.NUM_LAYERS(8)) bus ();

    layer_sched #(
        .NUM_LAYERS     (8),
        .STAGGER_CYCLES (4),
        .MIN_PERIOD     (100),
        .REFRESH_PERIOD (500),
        .BUSY_TIMEOUT   (200),
        .CNT_W          (24)
    ) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         fire_cnt [8];
    int         fire_cyc [8];
    int         multi_hot = 0;
    logic [7:0] start_prev = '0;
    logic [7:0] busy_model = '0;
    logic [7:0] stuck_mask = '0;
    int         drop_at = -1;
    logic       busy_prev = 1'b0;
    int         stag_cyc = -1;
    int         idle_cyc = -1;
    bit         stag_ev = 1'b0;
    bit         idle_ev = 1'b0;
    logic       stag_auto = 1'b0;
    int         to_cnt = 0;
    int         to_cyc = -1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_hist();
        for (int k = 0; k < 8; k++) begin
            fire_cnt[k] = 0;
            fire_cyc[k] = -1;
        end
    endtask

    // One clock: channel model, then observe outputs of the new cycle.
    task automatic step();
        @(posedge clk_in);
        #1;
        cyc++;
        busy_model = busy_model | start_prev;
        if (cyc == drop_at) busy_model = '0;
        bus.layer_busy_in = busy_model | stuck_mask;
        for (int k = 0; k < 8; k++) begin
            if (bus.start_out[k]) begin
                fire_cnt[k]++;
                fire_cyc[k] = cyc;
            end
        end
        if (bus.start_out[7]) drop_at = cyc + 21;
        if ($countones(bus.start_out) > 1) multi_hot++;
        start_prev = bus.start_out;
        if (bus.sched_busy_out && !busy_prev) begin
            stag_cyc  = cyc;
            stag_ev   = 1'b1;
            stag_auto = bus.auto_frame_out;
        end
        if (!bus.sched_busy_out && busy_prev) begin
            idle_cyc = cyc;
            idle_ev  = 1'b1;
        end
        busy_prev = bus.sched_busy_out;
        if (bus.timeout_out) begin
            to_cnt++;
            to_cyc = cyc;
        end
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic pulse_frame();
        bus.frame_rdy_in = 1'b1;
        step();
        bus.frame_rdy_in = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max);
        for (int i = 0; i < max && !idle_ev; i++) step();
        check_eq(tag, 32'(idle_ev), 1);
    endtask

    task automatic wait_stag(input string tag, input int max);
        for (int i = 0; i < max && !stag_ev; i++) step();
        check_eq(tag, 32'(stag_ev), 1);
    endtask

    task automatic wait_quiet(input string tag);
        int q = 0;
        for (int i = 0; i < 2000 && q < 5; i++) begin
            step();
            q = bus.sched_busy_out ? 0 : q + 1;
        end
        check_eq(tag, 32'(q >= 5), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int s;
        int i1;
        int i2;
        int total;

        rst_in            = 1'b1;
        bus.frame_rdy_in  = 1'b0;
        bus.auto_en_in    = 1'b0;
        bus.layer_busy_in = '0;
        clear_hist();
        repeat (3) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        cyc    = 0;

        // Reset state
        check_eq("rst_start",    32'(bus.start_out), 0);
        check_eq("rst_busy",     32'(bus.sched_busy_out), 0);
        check_eq("rst_auto",     32'(bus.auto_frame_out), 0);
        check_eq("rst_timeout",  32'(bus.timeout_out), 0);
        check_eq("rst_overrun",  32'(bus.overrun_cnt_out), 0);

        // 1/2: host frame at 10, second host frame at 70
        run_to(10);
        check_eq("t1_idle_before", 32'(bus.sched_busy_out), 0);
        pulse_frame();
        check_eq("t1_busy_at_11", 32'(bus.sched_busy_out), 1);
        check_eq("t1_stag_entry", 32'(stag_cyc), 11);
        run_to(70);
        pulse_frame();
        run_to(100);
        for (int k = 0; k < 8; k++) begin
            check_eq($sformatf("t1_start%0d_cyc", k), 32'(fire_cyc[k]), 32'(11 + 4 * k));
            check_eq($sformatf("t1_start%0d_cnt", k), 32'(fire_cnt[k]), 1);
        end
        check_eq("t1_onehot", 32'(multi_hot), 0);
        run_to(112);
        check_eq("t2_idle_cyc",    32'(idle_cyc), 111);
        check_eq("t2_restart_cyc", 32'(stag_cyc), 112);
        check_eq("t2_start0_cyc",  32'(fire_cyc[0]), 112);

        // 3: three host pulses during frame 2 -> one follow-up, overrun 2
        run_to(120); pulse_frame();
        run_to(125); pulse_frame();
        run_to(130); pulse_frame();
        run_to(150);
        check_eq("t3_overrun2",   32'(bus.overrun_cnt_out), 2);
        run_to(214);
        check_eq("t3_idle_cyc",   32'(idle_cyc), 212);
        check_eq("t3_follow_cyc", 32'(stag_cyc), 213);
        run_to(330);
        check_eq("t3_quiet_busy", 32'(bus.sched_busy_out), 0);
        check_eq("t3_single_follow", 32'(stag_cyc), 213);
        check_eq("t3_idle2_cyc",  32'(idle_cyc), 313);
        check_eq("t3_onehot",     32'(multi_hot), 0);
        check_eq("t3_no_timeout", 32'(to_cnt), 0);

        // 3b: 300 back-to-back pulses -> saturate at 255
        repeat (300) pulse_frame();
        check_eq("t3_overrun_sat", 32'(bus.overrun_cnt_out), 255);
        wait_quiet("t3_settle");
        check_eq("t3_overrun_hold", 32'(bus.overrun_cnt_out), 255);

        // 4: auto-refresh 500 cycles after entering IDLE
        bus.auto_en_in = 1'b1;
        pulse_frame();
        idle_ev = 1'b0;
        wait_idle("t4_idle_seen", 300);
        i1 = idle_cyc;
        stag_ev = 1'b0;
        wait_stag("t4_auto_seen", 600);
        check_eq("t4_auto_delay",  32'(stag_cyc - i1), 500);
        check_eq("t4_auto_flag",   32'(stag_auto), 1);
        check_eq("t4_auto_start0", 32'(fire_cyc[0]), 32'(stag_cyc));
        repeat (50) step();
        check_eq("t4_auto_mid",    32'(bus.auto_frame_out), 1);
        idle_ev = 1'b0;
        wait_idle("t4_idle2_seen", 200);
        check_eq("t4_auto_idle",   32'(bus.auto_frame_out), 0);
        i2 = idle_cyc;
        run_to(i2 + 499);
        pulse_frame();
        check_eq("t4_host_wins_cyc",  32'(stag_cyc), 32'(i2 + 500));
        check_eq("t4_host_wins_flag", 32'(bus.auto_frame_out), 0);
        check_eq("t4_host_start0",    32'(fire_cyc[0]), 32'(i2 + 500));
        bus.auto_en_in = 1'b0;
        wait_quiet("t4_settle");

        // 5: channel 3 stuck busy -> single timeout, 200 after WAIT_BUSY
        stuck_mask = 8'h08;
        to_cnt = 0;
        pulse_frame();
        s = cyc;
        idle_ev = 1'b0;
        wait_idle("t5_idle_seen", 400);
        check_eq("t5_timeout_cnt", 32'(to_cnt), 1);
        check_eq("t5_timeout_cyc", 32'(to_cyc), 32'(s + 232));
        check_eq("t5_idle_cyc",    32'(idle_cyc), 32'(s + 233));
        stuck_mask = '0;
        wait_quiet("t5_settle");

        // 6: reset while start_out[2] is high
        clear_hist();
        pulse_frame();
        s = cyc;
        run_to(s + 8);
        check_eq("t6_start2_high", 32'(bus.start_out), 4);
        #1 rst_in = 1'b1;
        #1;
        check_eq("t6_rst_start",   32'(bus.start_out), 0);
        check_eq("t6_rst_busy",    32'(bus.sched_busy_out), 0);
        check_eq("t6_rst_auto",    32'(bus.auto_frame_out), 0);
        check_eq("t6_rst_timeout", 32'(bus.timeout_out), 0);
        check_eq("t6_rst_overrun", 32'(bus.overrun_cnt_out), 0);
        #2 rst_in = 1'b0;
        busy_model = '0;
        start_prev = '0;
        drop_at    = -1;
        clear_hist();
        repeat (30) step();
        total = 0;
        for (int k = 0; k < 8; k++) total += fire_cnt[k];
        check_eq("t6_no_restart", 32'(total), 0);
        check_eq("t6_still_idle", 32'(bus.sched_busy_out), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
